// File: rtl/proc_pkg.sv
// Shared types and constants for the processor instruction feeder.
// Holds the feeder state encoding, core opcodes and the stop rule.
package proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5,
        S_ERROR = 3'd6
    } feed_state_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Opcodes 100-111 (bit 15 set) are not executed by the core.
    function automatic logic is_halt(input logic [15:0] w);
        logic [2:0] op;
        op = w[15:13];
        return !(op inside {OP_MV, OP_MVT, OP_ADD, OP_SUB});
    endfunction

endpackage

// File: rtl/proc_feeder.sv
// Instruction feeder: fetches ROM words and issues them to the core
// over the DIN/Run/Done handshake, stopping on halt, end or timeout.
module proc_feeder
    import proc_pkg::*;
#(
    parameter int AW      = 5,
    parameter int CW      = 16,
    parameter int TIMEOUT = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    output logic [AW-1:0] MemAddr,
    input  logic [15:0]   MemQ,
    output logic [15:0]   DIN,
    output logic          Run,
    input  logic          Done,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [CW-1:0] InstrCount
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] PC_LAST = '1;
    localparam logic [WW-1:0] W_LAST  = WW'(TIMEOUT - 1);

    feed_state_e   state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   din_q, din_d;
    logic          run_q, run_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic          error_q, error_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        din_d    = din_q;
        run_d    = 1'b0;
        busy_d   = busy_q;
        halted_d = halted_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        unique case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (Start) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    cnt_d    = '0;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (is_halt(MemQ)) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    state_d = S_ISSUE;
                    din_d   = MemQ;
                    run_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (Done) begin
                    cnt_d = cnt_q + 1'b1;
                    // End of memory stops rather than wrapping the PC.
                    if (pc_q == PC_LAST) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + 1'b1;
                    end
                end else if (wcnt_q == W_LAST) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            din_q    <= din_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign MemAddr    = pc_q;
    assign DIN        = din_q;
    assign Run        = run_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign Error      = error_q;
    assign InstrCount = cnt_q;

endmodule
